in1536_out128: RTL and testbench

IN1536_OUT128 -- requirements
Module: in1536_out128

---
 rtl/in1536_out128.sv | 79 +++++++
 tb/tb_in1536_out128.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/in1536_out128.sv
// in1536_out128: AXI-Stream width downsizer that splits each wide word into RATIO
// narrow beats, least-significant beat first, with zero-bubble word chaining.
module in1536_out128 #(
    parameter  int DWIDTH_IN  = 1536,
    parameter  int DWIDTH_OUT = 128,
    localparam int RATIO      = DWIDTH_IN / DWIDTH_OUT,
    localparam int CW         = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DWIDTH_IN-1:0]  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DWIDTH_OUT-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CW-1:0]         beat_cnt
);

    generate
        if ((DWIDTH_IN % DWIDTH_OUT) != 0 || RATIO < 2) begin : g_bad_ratio
            $error("in1536_out128: DWIDTH_IN must be an integer multiple (>=2) of DWIDTH_OUT");
        end
    endgenerate

    typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

    state_t                             state_q, state_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic                               last_q, last_d;
    logic [RATIO-1:0][DWIDTH_OUT-1:0]   hold_q, hold_d;
    logic                               at_last, s_xfer, m_xfer;

    always_comb begin
        at_last       = cnt_q == LAST_BEAT;
        m_axis_tvalid = state_q == SEND;
        m_axis_tlast  = m_axis_tvalid && at_last && last_q;
        m_axis_tdata  = hold_q[cnt_q];
        beat_cnt      = cnt_q;
        // Accepting during the final beat chains the next word with no idle cycle.
        s_axis_tready = rst_n && (state_q == EMPTY || (at_last && m_axis_tready));
        s_xfer        = s_axis_tvalid && s_axis_tready;
        m_xfer        = m_axis_tvalid && m_axis_tready;
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        hold_d        = hold_q;
        if (s_xfer) begin
            state_d = SEND;
            cnt_d   = '0;
            last_d  = s_axis_tlast;
            hold_d  = s_axis_tdata;
        end else if (m_xfer) begin
            state_d = at_last ? EMPTY : SEND;
            cnt_d   = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_in1536_out128.sv
// tb_in1536_out128: randomized and directed checks of the 1536-to-128 downsizer
// against a queue-of-beats reference model.
module tb_in1536_out128;
    localparam int DI = 1536;
    localparam int DO = 128;
    localparam int R  = DI / DO;

    typedef struct {
        logic [DO-1:0] d;
        logic          l;
        int            i;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DI-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [DO-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b1;
    logic [3:0]    beat_cnt;

    int  tests = 0;
    int  fails = 0;
    bit  rdy_rand = 1'b0;
    beat_t exp_q[$];

    in1536_out128 dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_ready),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DO-1:0] act, input logic [DO-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [DI-1:0] mk(input int base);
        logic [DI-1:0] w;
        for (int k = 0; k < R; k++) w[k*DO +: DO] = DO'(base + k);
        return w;
    endfunction

    // Downstream ready: held at 1 or randomized 50% per cycle.
    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reference model: queue of beats still owed downstream; inputs are stable at negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_m_valid", m_valid, 0);
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_beat_cnt", beat_cnt, 0);
        end else begin
            bit holding, exp_sr;
            holding = exp_q.size() != 0;
            exp_sr  = !holding || (exp_q.size() == 1 && m_ready);
            chk("m_valid", m_valid, holding);
            chk("s_ready", s_ready, exp_sr);
            if (holding) begin
                chk("m_data", m_data, exp_q[0].d);
                chk("m_last", m_last, exp_q[0].l);
                chk("beat_cnt", beat_cnt, DO'(exp_q[0].i));
                if (m_ready) void'(exp_q.pop_front());
            end
            if (s_valid && exp_sr)
                for (int k = 0; k < R; k++) exp_q.push_back('{s_data[k*DO +: DO], s_last && k == R-1, k});
        end
    end

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_word(input logic [DI-1:0] d, input logic l);
        bit ok = 1'b0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            ok = s_ready;
        end
        if (!ok) timeout("s_ready_wait");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = {DI{1'bx}};
        s_last  = 1'bx;
    endtask

    task automatic wait_empty();
        bit ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            ok = !m_valid;
        end
        if (!ok) timeout("drain_wait");
        #1;
        chk("scoreboard_drained", DO'(exp_q.size()), 0);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = m_valid;
        end
        if (!ok) timeout("m_valid_wait");
    endtask

    initial begin
        bit ok;
        int k;
        bit prev_stall;
        logic [DO-1:0] prev_d;
        logic [3:0] prev_c;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_s_ready", s_ready, 1);
        chk("post_reset_m_valid", m_valid, 0);

        // One word, ready held: 12 consecutive beats then valid drops.
        @(posedge clk); #1;
        send_word(mk(0), 1'b0);
        for (int b = 0; b < R; b++) begin
            @(negedge clk);
            chk("s1_valid", m_valid, 1);
            chk("s1_data", m_data, DO'(b));
            chk("s1_cnt", beat_cnt, DO'(b));
            chk("s1_last", m_last, 0);
        end
        @(negedge clk);
        chk("s1_valid_falls", m_valid, 0);

        // Three back-to-back words: 36 contiguous beats.
        @(posedge clk); #1;
        fork
            begin
                send_word(mk(256), 1'b0);
                send_word(mk(512), 1'b0);
                send_word(mk(768), 1'b0);
            end
            begin
                wait_valid(ok);
                for (int b = 0; b < 3*R && ok; b++) begin
                    if (b != 0) @(negedge clk);
                    chk("s2_no_bubble", m_valid, 1);
                    chk("s2_data", m_data, DO'(256 * (b / R + 1) + b % R));
                    if (b < 3*R - 1) chk("s2_s_ready_pulse", s_ready, (b == 11 || b == 23));
                end
            end
        join
        wait_empty();

        // Random downstream stalls: same ordering, data held while stalled.
        rdy_rand = 1'b1;
        @(posedge clk); #1;
        send_word(mk(0), 1'b0);
        k = 0;
        prev_stall = 1'b0;
        for (int n = 0; n < 400 && k < R; n++) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("s3_stall_data", m_data, prev_d);
                chk("s3_stall_cnt", beat_cnt, prev_c);
            end
            if (m_valid && m_ready) begin
                chk("s3_data", m_data, DO'(k));
                k++;
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_c = beat_cnt;
        end
        if (k != R) timeout("s3_beats");
        rdy_rand = 1'b0;
        wait_empty();

        // Two-word packet: tlast only on beat 23.
        @(posedge clk); #1;
        fork
            begin
                send_word(mk(100), 1'b0);
                send_word(mk(200), 1'b1);
            end
            begin
                wait_valid(ok);
                for (int b = 0; b < 2*R && ok; b++) begin
                    if (b != 0) @(negedge clk);
                    chk("s4_tlast", m_last, (b == 23));
                    chk("s4_data", m_data, DO'(b < R ? 100 + b : 200 + b - R));
                end
            end
        join
        wait_empty();

        // Asynchronous reset during beat 5.
        @(posedge clk); #1;
        send_word(mk(40), 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = m_valid && beat_cnt == 4'd5;
        end
        if (!ok) timeout("s5_beat5_wait");
        #2 rst_n = 1'b0;
        #1;
        chk("s5_async_m_valid", m_valid, 0);
        chk("s5_async_s_ready", s_ready, 0);
        chk("s5_async_cnt", beat_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("s5_release_s_ready", s_ready, 1);
        chk("s5_release_m_valid", m_valid, 0);
        @(posedge clk); #1;
        send_word(mk(60), 1'b0);
        @(negedge clk);
        chk("s5_restart_cnt", beat_cnt, 0);
        chk("s5_restart_data", m_data, DO'(60));
        wait_empty();

        // Randomized traffic on both sides.
        rdy_rand = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < 30; w++) begin
            logic [DI-1:0] d;
            for (int j = 0; j < DI / 32; j++) d[j*32 +: 32] = $urandom;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send_word(d, 1'($urandom_range(0, 1)));
        end
        rdy_rand = 1'b0;
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
